// File: rtl/delta_div_issue.sv
// delta_div_issue
// Takes {vid, FP16 delta, integer out-degree} events, converts the degree to
// FP16, presents delta/degree to an external combinational FP16 divider and
// queues {vid, quotient} in a small output buffer. Events with degree 0 are
// dropped and counted.
//
// Ports
//   clock, reset_n            : clock, async active-low reset
//   in_valid/in_ready         : event handshake (in_ready is combinational)
//   in_vid, in_delta, in_degree : event payload
//   div_opA, div_opB          : dividend/divisor to the divider (0 when idle)
//   div_quotient              : divider result, same cycle
//   out_valid/out_ready       : buffer head handshake
//   out_vid, out_value        : buffer head payload
//   drop_count                : saturating count of degree-0 drops
module delta_div_issue #(
  parameter int VID_W     = 16,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VID_W-1:0] in_vid,
  input  logic [15:0]      in_delta,
  input  logic [15:0]      in_degree,
  output logic [15:0]      div_opA,
  output logic [15:0]      div_opB,
  input  logic [15:0]      div_quotient,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VID_W-1:0] out_vid,
  output logic [15:0]      out_value,
  output logic [15:0]      drop_count
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_DEPTH);

  logic             r_s1_valid;
  logic [VID_W-1:0] r_s1_vid;
  logic [15:0]      r_s1_delta;
  logic [15:0]      r_s1_degree;

  logic             r_s2_valid;
  logic [VID_W-1:0] r_s2_vid;
  logic [15:0]      r_s2_opa;
  logic [15:0]      r_s2_opb;

  logic [VID_W-1:0] r_buf_vid [OUT_DEPTH];
  logic [15:0]      r_buf_val [OUT_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_drop_count;

  logic w_full, w_pop, w_s2_adv, w_s1_adv, w_s2_zero, w_push, w_drop;

  // Unsigned 16-bit integer to FP16, round-to-nearest-even, overflow to +inf.
  logic [3:0]  w_msb;
  logic [3:0]  w_sh;
  logic [11:0] w_man;
  logic [15:0] w_rem;
  logic [15:0] w_half;
  logic [5:0]  w_exp;
  logic [15:0] w_deg_fp;

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < 16; i++) begin
      if (r_s1_degree[i]) w_msb = 4'(i);
    end
    w_exp  = 6'd15 + {2'b00, w_msb};
    w_sh   = '0;
    w_rem  = '0;
    w_half = '0;
    if (w_msb <= 4'd10) begin
      w_man = 12'(r_s1_degree << (4'd10 - w_msb));
    end else begin
      w_sh   = w_msb - 4'd10;
      w_man  = 12'(r_s1_degree >> w_sh);
      w_rem  = r_s1_degree & ((16'd1 << w_sh) - 16'd1);
      w_half = 16'd1 << (w_sh - 4'd1);
      if ((w_rem > w_half) || ((w_rem == w_half) && w_man[0]))
        w_man = w_man + 12'd1;
    end
    // Rounding carried into bit 11: renormalise.
    if (w_man[11]) begin
      w_man = w_man >> 1;
      w_exp = w_exp + 6'd1;
    end
    if (r_s1_degree == 16'd0)  w_deg_fp = 16'h0000;
    else if (w_exp >= 6'd31)   w_deg_fp = 16'h7C00;
    else                       w_deg_fp = {1'b0, w_exp[4:0], w_man[9:0]};
  end

  // Only degree 0 converts to FP16 zero, so opB doubles as the drop flag.
  assign out_valid = (r_count != '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = out_valid && out_ready;
  assign w_s2_adv  = !w_full || w_pop;
  assign w_s1_adv  = !r_s2_valid || w_s2_adv;
  assign in_ready  = reset_n && (!r_s1_valid || w_s1_adv);
  assign w_s2_zero = (r_s2_opb == 16'h0000);
  assign w_push    = r_s2_valid && w_s2_adv && !w_s2_zero;
  assign w_drop    = r_s2_valid && w_s2_adv && w_s2_zero;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_vid    <= '0;
      r_s1_delta  <= '0;
      r_s1_degree <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_vid    <= '0;
      r_s2_opa    <= '0;
      r_s2_opb    <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_vid    <= in_vid;
          r_s1_delta  <= in_delta;
          r_s1_degree <= in_degree;
        end
      end
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_vid <= r_s1_vid;
          r_s2_opa <= r_s1_delta;
          r_s2_opb <= w_deg_fp;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop_count != 16'hFFFF))
        r_drop_count <= r_drop_count + 16'd1;
    end
  end

  // Storage needs no reset: nothing reads it until the count says it holds data.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_buf_vid[r_wr_ptr] <= r_s2_vid;
      r_buf_val[r_wr_ptr] <= div_quotient;
    end
  end

  assign out_vid    = out_valid ? r_buf_vid[r_rd_ptr] : '0;
  assign out_value  = out_valid ? r_buf_val[r_rd_ptr] : '0;
  assign div_opA    = r_s2_valid ? r_s2_opa : 16'h0000;
  assign div_opB    = r_s2_valid ? r_s2_opb : 16'h0000;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_delta_div_issue.sv
module tb_delta_div_issue;
  localparam int VID_W = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [VID_W-1:0]  in_vid = '0;
  logic [15:0]       in_delta = '0;
  logic [15:0]       in_degree = '0;
  logic [15:0]       div_opA, div_opB, div_quotient;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [VID_W-1:0]  out_vid;
  logic [15:0]       out_value;
  logic [15:0]       drop_count;

  always #5 clock = ~clock;

  delta_div_issue #(.VID_W(VID_W), .OUT_DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vid(in_vid), .in_delta(in_delta), .in_degree(in_degree),
    .div_opA(div_opA), .div_opB(div_opB), .div_quotient(div_quotient),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vid(out_vid), .out_value(out_value), .drop_count(drop_count)
  );

  typedef struct packed { logic [15:0] vid; logic [15:0] delta; logic [15:0] deg; } ev_t;
  typedef struct packed { logic [15:0] vid; logic [15:0] val; } out_t;

  ev_t  acc_q[$];
  out_t obs_q[$];
  out_t exp_q[$];
  int   model_drops = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  // ---------------- reference model (real arithmetic) ----------------
  function automatic real h2r(input logic [15:0] h);
    logic [63:0] b;
    real v;
    if (h[14:10] == 5'd0) begin
      v = real'(h[9:0]) / 16777216.0;
      if (h[15]) v = -v;
      return v;
    end
    b = {h[15], 11'(int'(h[14:10]) + 1008), h[9:0], 42'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [15:0] r2h(input real v);
    logic [63:0] b;
    int          ee;
    logic [10:0] m;
    logic [41:0] rest;
    b = $realtobits(v);
    if (b[62:0] == 63'd0) return {b[63], 15'd0};
    ee = int'(b[62:52]) - 1008;
    if (ee <= 0) return {b[63], 15'd0};
    m    = {1'b0, b[51:42]};
    rest = b[41:0];
    if ((rest > 42'h200_0000_0000) || ((rest == 42'h200_0000_0000) && m[0]))
      m = m + 11'd1;
    if (m[10]) begin
      m  = 11'd0;
      ee = ee + 1;
    end
    if (ee >= 31) return {b[63], 5'h1F, 10'd0};
    return {b[63], ee[4:0], m[9:0]};
  endfunction

  function automatic logic [15:0] f_div(input logic [15:0] a, input logic [15:0] b);
    if ((b == 16'h0000) || (b[14:10] == 5'h1F)) return 16'h0000;
    return r2h(h2r(a) / h2r(b));
  endfunction

  function automatic logic [15:0] cvt_deg(input logic [15:0] g);
    if (g == 16'd0) return 16'h0000;
    return r2h(real'(g));
  endfunction

  function automatic out_t model_out(input ev_t e);
    out_t o;
    o.vid = e.vid;
    o.val = f_div(e.delta, cvt_deg(e.deg));
    return o;
  endfunction

  function automatic logic [15:0] rand_delta();
    return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
  endfunction

  function automatic logic [15:0] rand_deg();
    case ($urandom_range(0, 7))
      0:          return 16'd0;
      1, 2, 3:    return 16'($urandom_range(1, 2048));
      4, 5:       return 16'($urandom);
      default:    return 16'($urandom_range(65500, 65535));
    endcase
  endfunction

  // The external divider.
  always_comb div_quotient = f_div(div_opA, div_opB);

  // Record accepted events and popped outputs.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (in_valid && in_ready) begin
        ev_t e;
        e.vid = in_vid; e.delta = in_delta; e.deg = in_degree;
        acc_q.push_back(e);
        if (in_degree == 16'd0) model_drops++;
      end
      if (out_valid && out_ready) begin
        out_t o;
        o.vid = out_vid; o.val = out_value;
        obs_q.push_back(o);
      end
    end
  end

  task automatic build_exp();
    exp_q.delete();
    foreach (acc_q[i]) if (acc_q[i].deg != 16'd0) exp_q.push_back(model_out(acc_q[i]));
  endtask

  task automatic clear_sb();
    acc_q.delete();
    obs_q.delete();
  endtask

  task automatic send(input logic [15:0] vid, input logic [15:0] d, input logic [15:0] g);
    logic rdy;
    bit   done;
    done = 0;
    in_vid = vid; in_delta = d; in_degree = g; in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clock); rdy = in_ready;
      @(posedge clock); #1;
      if (rdy) done = 1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 50 cycles");
    end
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    for (int c = 0; c < 200 && obs_q.size() < n; c++) @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b required 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid); else n_pass++;
    n_checks++; if ({out_vid, out_value} !== 32'd0) $display("FAIL rst_out_data: got %h/%h required 0", out_vid, out_value); else n_pass++;
    n_checks++; if ({div_opA, div_opB} !== 32'd0) $display("FAIL rst_div_ops: got %h/%h required 0", div_opA, div_opB); else n_pass++;
    n_checks++; if (drop_count !== 16'd0) $display("FAIL rst_drop_count: got %0d required 0", drop_count); else n_pass++;
    model_drops = 0;
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b required 1", in_ready); else n_pass++;
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(16'd5, 16'h3C00, 16'd4);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_early_valid: got %b required 0", out_valid); else n_pass++;
    @(posedge clock); #1;
    n_checks++; if (div_opA !== 16'h3C00) $display("FAIL single_opA: got %h required 3c00", div_opA); else n_pass++;
    n_checks++; if (div_opB !== 16'h4400) $display("FAIL single_opB: got %h required 4400", div_opB); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_t1_valid: got %b required 0", out_valid); else n_pass++;
    @(posedge clock); #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b required 1", out_valid); else n_pass++;
    n_checks++; if (out_vid !== 16'd5) $display("FAIL single_vid: got %0d required 5", out_vid); else n_pass++;
    n_checks++; if (out_value !== 16'h3400) $display("FAIL single_value: got %h required 3400", out_value); else n_pass++;
    @(posedge clock); #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_popped: got %b required 0", out_valid); else n_pass++;
    clear_sb();
  endtask

  task automatic test_rounding();
    logic [15:0] degs [3];
    logic [15:0] opbs [3];
    logic [15:0] ev;
    degs[0] = 16'd3;     opbs[0] = 16'h4200;
    degs[1] = 16'd2049;  opbs[1] = 16'h6800;
    degs[2] = 16'd65535; opbs[2] = 16'h7C00;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(16'(10 + k), 16'h3C00, degs[k]);
      @(posedge clock); #1;
      n_checks++; if (div_opB !== opbs[k]) $display("FAIL round_opB[%0d]: got %h required %h", degs[k], div_opB, opbs[k]); else n_pass++;
      @(posedge clock); #1;
      ev = (k == 0) ? 16'h3555 : f_div(16'h3C00, cvt_deg(degs[k]));
      n_checks++; if ({out_valid, out_value} !== {1'b1, ev}) $display("FAIL round_value[%0d]: got v=%b %h required v=1 %h", degs[k], out_valid, out_value, ev); else n_pass++;
      @(posedge clock); #1;
    end
    clear_sb();
  endtask

  task automatic test_drop();
    out_ready = 1'b1;
    send(16'd30, rand_delta(), 16'd7);
    send(16'd31, rand_delta(), 16'd0);
    send(16'd32, rand_delta(), 16'd9);
    drain(2);
    build_exp();
    n_checks++; if (obs_q.size() !== 2) $display("FAIL drop_out_count: got %0d required 2", obs_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL drop_entry[%0d]: got %h/%h required %h/%h", i, obs_q[i].vid, obs_q[i].val, exp_q[i].vid, exp_q[i].val);
      else n_pass++;
    end
    n_checks++; if (drop_count !== 16'(model_drops)) $display("FAIL drop_count: got %0d required %0d", drop_count, model_drops); else n_pass++;
    clear_sb();
  endtask

  task automatic test_backpressure();
    logic [15:0] degs [5];
    logic        rdy;
    int          cyc;
    for (int k = 0; k < 5; k++) degs[k] = 16'($urandom_range(1, 65535));
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(16'(20 + k), rand_delta(), degs[k]);
    in_vid = 16'd24; in_delta = rand_delta(); in_degree = degs[4]; in_valid = 1'b1;
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b required 0", in_ready); else n_pass++;
    n_checks++; if (out_vid !== 16'd20) $display("FAIL bp_head: got %0d required 20", out_vid); else n_pass++;
    n_checks++; if (div_opB !== cvt_deg(degs[2])) $display("FAIL bp_s2_opB: got %h required %h", div_opB, cvt_deg(degs[2])); else n_pass++;
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++; if ({in_ready, out_valid, out_vid} !== {2'b01, 16'd20}) $display("FAIL bp_hold: got rdy=%b v=%b vid=%0d required 0/1/20", in_ready, out_valid, out_vid); else n_pass++;
    @(posedge clock); #1;
    out_ready = 1'b1;
    cyc = 0;
    while (obs_q.size() < 5 && cyc < 40) begin
      @(negedge clock); rdy = in_ready; cyc++;
      @(posedge clock); #1;
      if (rdy) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n_checks++; if (cyc !== 5) $display("FAIL bp_drain_cycles: got %0d required 5", cyc); else n_pass++;
    build_exp();
    n_checks++; if (obs_q.size() !== 5) $display("FAIL bp_out_count: got %0d required 5", obs_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL bp_entry[%0d]: got %h/%h required %h/%h", i, obs_q[i].vid, obs_q[i].val, exp_q[i].vid, exp_q[i].val);
      else n_pass++;
    end
    repeat (3) @(posedge clock);
    #1;
    clear_sb();
  endtask

  task automatic test_full_push_pop();
    logic [15:0] g3;
    g3 = 16'($urandom_range(1, 4000));
    out_ready = 1'b0;
    send(16'd40, rand_delta(), 16'($urandom_range(1, 65535)));
    send(16'd41, rand_delta(), 16'($urandom_range(1, 65535)));
    send(16'd42, rand_delta(), g3);
    @(posedge clock); #1;
    n_checks++; if (div_opB !== cvt_deg(g3)) $display("FAIL fpp_s2_opB: got %h required %h", div_opB, cvt_deg(g3)); else n_pass++;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    n_checks++; if ({out_valid, out_vid} !== {1'b1, 16'd41}) $display("FAIL fpp_head: got v=%b vid=%0d required 1/41", out_valid, out_vid); else n_pass++;
    n_checks++; if (div_opB !== 16'h0000) $display("FAIL fpp_s2_empty: got %h required 0000", div_opB); else n_pass++;
    @(posedge clock); #1;
    n_checks++; if ({out_valid, out_vid} !== {1'b1, 16'd41}) $display("FAIL fpp_stable: got v=%b vid=%0d required 1/41", out_valid, out_vid); else n_pass++;
    drain(3);
    build_exp();
    n_checks++; if (obs_q.size() !== 3) $display("FAIL fpp_out_count: got %0d required 3", obs_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL fpp_entry[%0d]: got %h/%h required %h/%h", i, obs_q[i].vid, obs_q[i].val, exp_q[i].vid, exp_q[i].val);
      else n_pass++;
    end
    clear_sb();
  endtask

  task automatic test_random();
    logic rdy;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock); rdy = in_ready;
      @(posedge clock); #1;
      if (!in_valid || rdy) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_vid    = 16'($urandom);
        in_delta  = rand_delta();
        in_degree = rand_deg();
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid = 1'b0;
    build_exp();
    drain(exp_q.size());
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL rand_out_count: got %0d required %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rand_entry[%0d]: got %h/%h required %h/%h", i, obs_q[i].vid, obs_q[i].val, exp_q[i].vid, exp_q[i].val);
      else n_pass++;
    end
    n_checks++; if (drop_count !== 16'(model_drops)) $display("FAIL rand_drop_count: got %0d required %0d", drop_count, model_drops); else n_pass++;
    clear_sb();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(16'(50 + k), rand_delta(), 16'($urandom_range(1, 65535)));
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({out_valid, out_vid, out_value} !== 33'd0) $display("FAIL mid_rst_out: got v=%b %h/%h required 0", out_valid, out_vid, out_value); else n_pass++;
    n_checks++; if ({div_opA, div_opB} !== 32'd0) $display("FAIL mid_rst_div: got %h/%h required 0", div_opA, div_opB); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b required 0", in_ready); else n_pass++;
    n_checks++; if (drop_count !== 16'd0) $display("FAIL mid_rst_drops: got %0d required 0", drop_count); else n_pass++;
    clear_sb();
    model_drops = 0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_release_ready: got %b required 1", in_ready); else n_pass++;
    @(posedge clock); #1;
    out_ready = 1'b1;
    send(16'd60, rand_delta(), 16'($urandom_range(1, 65535)));
    send(16'd61, rand_delta(), 16'($urandom_range(1, 65535)));
    drain(2);
    build_exp();
    n_checks++; if (obs_q.size() !== 2) $display("FAIL mid_out_count: got %0d required 2", obs_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL mid_entry[%0d]: got %h/%h required %h/%h", i, obs_q[i].vid, obs_q[i].val, exp_q[i].vid, exp_q[i].val);
      else n_pass++;
    end
    clear_sb();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rounding();
    test_drop();
    test_backpressure();
    test_full_push_pop();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
